// File: rtl/control_jugada_spi.sv
// Remote-move receiver: oversamples a raw SPI link, assembles 8-bit frames,
// validates them and hands accepted moves to the game FSM via valid/ready.
module control_jugada_spi #(
   parameter logic [4:0]  HEADER         = 5'b10100,
   parameter int unsigned MAX_JUGADA     = 6,
   parameter int unsigned TIMEOUT_CYCLES = 50000000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       mosi,
   input  logic       ss,
   input  logic       turno_remoto,
   input  logic       jugada_ready,
   output logic [2:0] jugada,
   output logic       jugada_valid,
   output logic       error_pulse,
   output logic [2:0] error_code,
   output logic [7:0] error_cnt,
   output logic       ocupado
);
   typedef enum logic [1:0] {IDLE, RECIBIENDO, VALIDAR, ESPERA_SS} state_t;
   typedef enum logic [2:0] {
      ERR_NONE    = 3'd0,
      ERR_HEADER  = 3'd1,
      ERR_RANGE   = 3'd2,
      ERR_TURN    = 3'd3,
      ERR_ABORT   = 3'd4,
      ERR_TIMEOUT = 3'd5,
      ERR_OVERRUN = 3'd6
   } err_t;

   localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
   logic                   sck_prev, ss_prev;
   logic                   sck_s, mosi_s, ss_s;
   logic                   sck_rise, ss_fall, ss_rise;

   state_t        state, state_next;
   logic [7:0]    shift_reg, shift_next;
   logic [3:0]    bit_cnt, bit_cnt_next;
   logic [TW-1:0] timeout_cnt, timeout_next;
   logic          err_event, accept;
   err_t          err_next;

   // Presets match an idle bus so leaving reset never looks like an ss edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         sck_prev  <= 1'b0;
         ss_prev   <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         sck_prev  <= sck_s;
         ss_prev   <= ss_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev;
   assign ss_fall  = ~ss_s & ss_prev;
   assign ss_rise  = ss_s & ~ss_prev;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next   = state;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt;
      timeout_next = timeout_cnt;
      err_event    = 1'b0;
      err_next     = ERR_NONE;
      accept       = 1'b0;
      ocupado      = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall) begin
               state_next   = RECIBIENDO;
               bit_cnt_next = '0;
               timeout_next = '0;
            end
         end
         RECIBIENDO: begin
            ocupado = 1'b1;
            if (sck_rise) begin
               shift_next   = {shift_reg[6:0], mosi_s};
               bit_cnt_next = bit_cnt + 4'd1;
               timeout_next = '0;
            end else begin
               timeout_next = timeout_cnt + TW'(1);
            end
            // A bit landing together with ss_rise counts before the abort check.
            if (sck_rise && bit_cnt == 4'd7) begin
               state_next = VALIDAR;
            end else if (ss_rise) begin
               err_event  = 1'b1;
               err_next   = ERR_ABORT;
               state_next = IDLE;
            end else if (!sck_rise && timeout_cnt == TIMEOUT_LAST) begin
               err_event  = 1'b1;
               err_next   = ERR_TIMEOUT;
               state_next = ESPERA_SS;
            end
         end
         VALIDAR: begin
            if (shift_reg[7:3] != HEADER) begin
               err_event = 1'b1;
               err_next  = ERR_HEADER;
            end else if (32'(shift_reg[2:0]) > MAX_JUGADA) begin
               err_event = 1'b1;
               err_next  = ERR_RANGE;
            end else if (!turno_remoto) begin
               err_event = 1'b1;
               err_next  = ERR_TURN;
            end else if (jugada_valid && !jugada_ready) begin
               err_event = 1'b1;
               err_next  = ERR_OVERRUN;
            end else begin
               accept = 1'b1;
            end
            state_next = ss_s ? IDLE : ESPERA_SS;
         end
         ESPERA_SS: begin
            if (ss_rise) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         timeout_cnt  <= '0;
         jugada       <= '0;
         jugada_valid <= 1'b0;
         error_pulse  <= 1'b0;
         error_code   <= '0;
         error_cnt    <= '0;
      end else begin
         state       <= state_next;
         shift_reg   <= shift_next;
         bit_cnt     <= bit_cnt_next;
         timeout_cnt <= timeout_next;
         // A move accepted while the old one is being consumed replaces it.
         if (accept) begin
            jugada       <= shift_reg[2:0];
            jugada_valid <= 1'b1;
         end else if (jugada_valid && jugada_ready) begin
            jugada_valid <= 1'b0;
         end
         error_pulse <= err_event;
         if (err_event) begin
            error_code <= err_next;
            if (error_cnt != 8'hFF) error_cnt <= error_cnt + 8'd1;
         end
      end
   end
endmodule
